pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It collects hazard and busy conditions from IF, ID, EX and MEM and drives the shared `StallBus` vector consumed by every stage register. It tracks the load in EX for load-use detection, sequences the multi-cycle mult/div unit, and redirects the PC on a WB-stage exception.

## Interface
Parameters:
- DIV_CYCLES, 32: iterative divide latency in busy cycles.
- MUL_CYCLES, 2: multiply latency in busy cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- if_stallreq  in  1  inst SRAM not ready.
- mem_stallreq  in  1  data SRAM not ready.
- id_load  in  1  instruction in ID is a load.
- id_load_waddr  in  5  destination register of that load.
- id_rs, id_rt  in  5 each  source registers read in ID.
- id_use_rs, id_use_rt  in  1 each  the ID instruction reads rs / rt.
- ex_div_start  in  1  div/divu in EX, first cycle.
- ex_mul_start  in  1  mult/multu in EX, first cycle.
- wb_excp  in  1  exception committed in WB.
- wb_excp_pc  in  32  handler address.
- stall  out  `StallBus` (6)  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB. `Stop`=1.
- flush  out  1  clear all stage registers.
- new_pc  out  32  redirect target. Valid only while flush=1.
- md_busy  out  1  mult/div unit is iterating.
- md_done  out  1  one-cycle pulse: HI/LO result valid.

## Operation
- Stall encoding is thermometer only: stall[k]=1 for every k≤n, where n is the deepest stalled stage. The stage after n sees NoStop and receives a bubble.
- Request priority, highest first:
  - flush: stall=0.
  - mem_stallreq: n=4.
  - md_busy, or ex_div_start / ex_mul_start in the current cycle: n=3.
  - load-use: n=2.
  - if_stallreq: n=1.
  - none of the above: stall=0.
- Load scoreboard, registered ex_ld_vld / ex_ld_waddr:
  - When stall[2]=NoStop: capture id_load / id_load_waddr.
  - When stall[2]=Stop and stall[3]=NoStop: clear vld (a bubble enters EX).
  - When stall[3]=Stop: hold.
  - On flush: clear.
- load-use = ex_ld_vld & ex_ld_waddr≠0 & ((id_use_rs & id_rs==ex_ld_waddr) | (id_use_rt & id_rt==ex_ld_waddr)).
- Register $0 never causes a hazard.
- MD FSM states:
  - IDLE -> BUSY on ex_div_start (cnt=DIV_CYCLES-1) or ex_mul_start (cnt=MUL_CYCLES-1). If both are asserted, div wins.
  - BUSY: cnt decrements each cycle. At cnt==0 -> DONE.
  - DONE: md_done=1 and the EX stall is released. -> IDLE next cycle.
  - In BUSY, the count continues while mem_stallreq is asserted.
  - flush in any state -> IDLE; cnt cleared; no md_done.
- md_busy = (state==BUSY).
- Flush: a registered one-cycle pulse.
  - wb_excp in cycle t -> flush=1 and new_pc=wb_excp_pc in cycle t+1.
  - A wb_excp arriving while flush=1 is ignored.

## Timing
- Reset values: stall=0, flush=0, new_pc=0, md_busy=0, md_done=0, FSM=IDLE, scoreboard cleared.
- stall is combinational from the request inputs plus registered state, within the same cycle.
- flush and new_pc are registered, with 1-cycle latency.
- Load-use costs exactly one bubble unless a higher-priority stall intervenes.
- Divide occupancy: the start cycle, then DIV_CYCLES BUSY cycles, then DONE. EX is stalled for 1+DIV_CYCLES cycles and released in DONE. Multiply follows the same pattern with MUL_CYCLES.
- mem_stallreq during a load-use cycle: stall=0x1F. Scoreboard holds, so the load-use bubble still occurs after MEM releases.
- rst mid-operation: all state is cleared on the next edge, with no md_done pulse.

## Structure
- Shared defines header (existing lib defines) holds:
  - `StallBus`, `Stop`, `NoStop`.
  - MD FSM state encodings (2 bits): MD_IDLE, MD_BUSY, MD_DONE.
- One sub-module, md_seq: MD FSM plus down-counter, with ports start_div, start_mul, flush, busy, done.
- pipe_ctrl contains the priority encoder, scoreboard and flush register.

## Test plan
- Load-use, rs path: lw $5 in ID (id_load=1, waddr=5); next cycle ID reads rs=5 with id_use_rs=1 -> stall=6'b000111 for one cycle, then 0. Repeat with waddr=0 -> no stall.
- Divide: ex_div_start at t0 -> stall=6'b001111 for t0..t0+32; md_busy=1 for 32 cycles; md_done=1 and stall=0 at t0+33.
- Mem stall inside divide: mem_stallreq=1 at BUSY cnt=10 for 3 cycles -> stall=6'b011111 on those cycles; md_done still at t0+33.
- Flush mid-divide: wb_excp=1, wb_excp_pc=0xBFC00380 at BUSY cnt=20 -> next cycle flush=1, new_pc=0xBFC00380, stall=0, md_busy=0; md_done never asserts; scoreboard cleared.
- Priority: if_stallreq=1 and load-use in the same cycle -> stall=6'b000111. if_stallreq alone -> stall=6'b000011.
- Reset: rst asserted during BUSY with ex_ld_vld=1 -> next cycle all outputs 0; an immediate ID read of the old load register gives no stall.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall bus type, stop encodings and mult/div FSM states.
package pipe_ctrl_pkg;
   localparam int STALL_W = 6;
   typedef logic [STALL_W-1:0] stall_bus_t;
   localparam logic STOP = 1'b1;
   localparam logic NO_STOP = 1'b0;
   typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_BUSY = 2'd1, MD_DONE = 2'd2} md_state_t;
   // Thermometer mask stopping stages 0..n; n<0 yields no stall.
   function automatic stall_bus_t stall_upto(input int n);
      stall_upto = stall_bus_t'((1 << (n + 1)) - 1);
   endfunction
endpackage

// File: rtl/pipe_ctrl_md_seq.sv
// md_seq: mult/div occupancy FSM with a latency down-counter.
module md_seq
   import pipe_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = 32,
   parameter int MUL_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic start_div,
   input  logic start_mul,
   input  logic flush,
   output logic busy,
   output logic done
);
   localparam int CW = $clog2((DIV_CYCLES > MUL_CYCLES ? DIV_CYCLES : MUL_CYCLES) + 1);
   md_state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      busy     = state == MD_BUSY;
      done     = state == MD_DONE;
      if (flush) begin
         state_nx = MD_IDLE;
         cnt_nx   = '0;
      end else if (state == MD_IDLE && (start_div || start_mul)) begin
         state_nx = MD_BUSY;
         cnt_nx   = start_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
      end else if (state == MD_BUSY) begin
         state_nx = cnt == '0 ? MD_DONE : MD_BUSY;
         cnt_nx   = cnt == '0 ? cnt : cnt - CW'(1);
      end else if (state == MD_DONE) begin
         state_nx = MD_IDLE;
      end
   end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall priority encoder, load-use scoreboard and
// exception flush/redirect register for the five-stage MIPS pipeline.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = 32,
   parameter int MUL_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_stallreq,
   input  logic        mem_stallreq,
   input  logic        id_load,
   input  logic [4:0]  id_load_waddr,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        ex_div_start,
   input  logic        ex_mul_start,
   input  logic        wb_excp,
   input  logic [31:0] wb_excp_pc,
   output stall_bus_t  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        md_busy,
   output logic        md_done
);
   logic       ex_ld_vld;
   logic [4:0] ex_ld_waddr;
   logic       take, load_use, md_stall;
   // An exception arriving during the flush pulse is dropped.
   assign take = wb_excp & ~flush;
   md_seq #(.DIV_CYCLES(DIV_CYCLES), .MUL_CYCLES(MUL_CYCLES)) u_md (
      .clk       (clk),
      .rst       (rst),
      .start_div (ex_div_start),
      .start_mul (ex_mul_start),
      .flush     (take | flush),
      .busy      (md_busy),
      .done      (md_done)
   );
   always_comb begin
      load_use = ex_ld_vld && ex_ld_waddr != 5'd0 &&
                 ((id_use_rs && id_rs == ex_ld_waddr) || (id_use_rt && id_rt == ex_ld_waddr));
      md_stall = md_busy | ex_div_start | ex_mul_start;
      stall    = flush        ? '0 :
                 mem_stallreq ? stall_upto(4) :
                 md_stall     ? stall_upto(3) :
                 load_use     ? stall_upto(2) :
                 if_stallreq  ? stall_upto(1) : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         flush       <= 1'b0;
         new_pc      <= '0;
         ex_ld_vld   <= 1'b0;
         ex_ld_waddr <= '0;
      end else begin
         flush <= take;
         if (take) new_pc <= wb_excp_pc;
         // ID advancing refills EX; ID stopped with EX moving leaves a bubble.
         if (take | flush) ex_ld_vld <= 1'b0;
         else if (stall[2] == NO_STOP) begin
            ex_ld_vld   <= id_load;
            ex_ld_waddr <= id_load_waddr;
         end else if (stall[3] != STOP) ex_ld_vld <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard-driven scenario bench for pipe_ctrl.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;
   logic clk = 1'b0;
   logic rst, if_stallreq, mem_stallreq, id_load, id_use_rs, id_use_rt;
   logic ex_div_start, ex_mul_start, wb_excp;
   logic [4:0] id_load_waddr, id_rs, id_rt;
   logic [31:0] wb_excp_pc, new_pc;
   stall_bus_t stall;
   logic flush, md_busy, md_done;
   localparam stall_bus_t S0 = 6'b000000, S_IF = 6'b000011, S_LU = 6'b000111;
   localparam stall_bus_t S_MD = 6'b001111, S_MEM = 6'b011111;
   typedef struct {string nm; logic [40:0] v;} exp_t;
   typedef struct packed {
      logic ld; logic [4:0] w; logic [4:0] rs; logic urs;
      logic [4:0] rt; logic urt; logic ifs; logic mem; stall_bus_t s;
   } id_t;
   exp_t q[$];
   int passed = 0, total = 0;
   always #5 clk = ~clk;
   pipe_ctrl dut (
      .clk(clk), .rst(rst), .if_stallreq(if_stallreq), .mem_stallreq(mem_stallreq),
      .id_load(id_load), .id_load_waddr(id_load_waddr), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_div_start(ex_div_start),
      .ex_mul_start(ex_mul_start), .wb_excp(wb_excp), .wb_excp_pc(wb_excp_pc),
      .stall(stall), .flush(flush), .new_pc(new_pc), .md_busy(md_busy), .md_done(md_done)
   );
   function automatic logic [40:0] pack(stall_bus_t s, logic f, logic [31:0] pc, logic b, logic d);
      return {s, f, pc, b, d};
   endfunction
   // new_pc only carries meaning while flush is high.
   function automatic logic [40:0] obs();
      return pack(stall, flush, flush ? new_pc : 32'h0, md_busy, md_done);
   endfunction
   function automatic id_t row(logic ld, logic [4:0] w, logic [4:0] rs, logic urs, logic [4:0] rt,
                               logic urt, logic ifs, logic mem, stall_bus_t s);
      return '{ld, w, rs, urs, rt, urt, ifs, mem, s};
   endfunction
   task automatic push(string nm, stall_bus_t s, logic f, logic [31:0] pc, logic b, logic d);
      q.push_back('{nm, pack(s, f, pc, b, d)});
   endtask
   task automatic next();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_in();
      rst = 1'b0; if_stallreq = 1'b0; mem_stallreq = 1'b0; id_load = 1'b0;
      id_load_waddr = '0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      ex_div_start = 1'b0; ex_mul_start = 1'b0; wb_excp = 1'b0; wb_excp_pc = '0;
   endtask
   task automatic test_reset();
      exp_t e;
      idle_in();
      rst = 1'b1;
      next();
      next();
      push("reset_outputs", S0, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      e = q.pop_front();
      total++;
      if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.nm, obs(), e.v);
      else passed++;
      total++;
      if (new_pc !== 32'h0) $display("FAIL reset_new_pc: got %h want 00000000", new_pc);
      else passed++;
      rst = 1'b0;
   endtask
   task automatic test_load_use();
      id_t t[10];
      exp_t e;
      t[0] = row(1, 5, 0, 0, 0, 0, 0, 0, S0);
      t[1] = row(0, 0, 5, 1, 0, 0, 0, 0, S_LU);
      t[2] = row(0, 0, 5, 1, 0, 0, 0, 0, S0);
      t[3] = row(1, 0, 0, 0, 0, 0, 0, 0, S0);
      t[4] = row(0, 0, 0, 1, 0, 1, 0, 0, S0);
      t[5] = row(1, 9, 9, 0, 0, 0, 0, 0, S0);
      t[6] = row(0, 0, 9, 0, 9, 1, 0, 0, S_LU);
      t[7] = row(0, 0, 9, 1, 0, 0, 0, 0, S0);
      t[8] = row(1, 12, 0, 0, 0, 0, 0, 0, S0);
      t[9] = row(0, 0, 12, 0, 12, 0, 0, 0, S0);
      for (int k = 0; k < 10; k++) begin
         next();
         idle_in();
         {id_load, id_load_waddr, id_rs, id_use_rs, id_rt, id_use_rt, if_stallreq, mem_stallreq} =
            {t[k].ld, t[k].w, t[k].rs, t[k].urs, t[k].rt, t[k].urt, t[k].ifs, t[k].mem};
         push($sformatf("load_use_c%0d", k), t[k].s, 1'b0, 32'h0, 1'b0, 1'b0);
         #1;
         e = q.pop_front();
         total++;
         if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.nm, obs(), e.v);
         else passed++;
      end
   endtask
   task automatic test_priority();
      id_t t[10];
      exp_t e;
      t[0] = row(1, 7, 0, 0, 0, 0, 0, 0, S0);
      t[1] = row(0, 0, 7, 1, 0, 0, 1, 0, S_LU);
      t[2] = row(0, 0, 7, 1, 0, 0, 1, 0, S_IF);
      t[3] = row(0, 0, 0, 0, 0, 0, 0, 0, S0);
      t[4] = row(1, 4, 0, 0, 0, 0, 0, 0, S0);
      t[5] = row(0, 0, 0, 0, 4, 1, 0, 1, S_MEM);
      t[6] = row(0, 0, 0, 0, 4, 1, 0, 1, S_MEM);
      t[7] = row(0, 0, 0, 0, 4, 1, 0, 0, S_LU);
      t[8] = row(0, 0, 0, 0, 4, 1, 0, 0, S0);
      t[9] = row(0, 0, 0, 0, 0, 0, 1, 0, S_IF);
      for (int k = 0; k < 10; k++) begin
         next();
         idle_in();
         {id_load, id_load_waddr, id_rs, id_use_rs, id_rt, id_use_rt, if_stallreq, mem_stallreq} =
            {t[k].ld, t[k].w, t[k].rs, t[k].urs, t[k].rt, t[k].urt, t[k].ifs, t[k].mem};
         push($sformatf("priority_c%0d", k), t[k].s, 1'b0, 32'h0, 1'b0, 1'b0);
         #1;
         e = q.pop_front();
         total++;
         if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.nm, obs(), e.v);
         else passed++;
      end
   endtask
   task automatic test_md(string nm, bit div, bit mul, bit mem);
      int lat;
      exp_t e;
      lat = div ? 32 : 2;
      for (int k = 0; k <= lat + 2; k++) begin
         next();
         idle_in();
         ex_div_start = div && k == 0;
         ex_mul_start = mul && k == 0;
         mem_stallreq = mem && k >= 22 && k <= 24;
         push($sformatf("%s_c%0d", nm, k), k > lat ? S0 : (mem_stallreq ? S_MEM : S_MD), 1'b0, 32'h0,
              k >= 1 && k <= lat, k == lat + 1);
         #1;
         e = q.pop_front();
         total++;
         if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.nm, obs(), e.v);
         else passed++;
      end
   endtask
   task automatic test_flush();
      exp_t e;
      for (int k = -1; k <= 30; k++) begin
         next();
         idle_in();
         id_load = k == -1;
         id_load_waddr = k == -1 ? 5'd6 : 5'd0;
         ex_div_start = k == 0;
         wb_excp = k == 12 || k == 13;
         wb_excp_pc = k == 12 ? 32'hBFC0_0380 : 32'h1234_5678;
         id_rs = k >= 14 ? 5'd6 : 5'd0;
         id_use_rs = k >= 14;
         if (k == -1) push("flush_pre", S0, 1'b0, 32'h0, 1'b0, 1'b0);
         else if (k <= 12) push($sformatf("flush_div_c%0d", k), S_MD, 1'b0, 32'h0, k >= 1, 1'b0);
         else if (k == 13) push("flush_pulse", S0, 1'b1, 32'hBFC0_0380, 1'b0, 1'b0);
         else push($sformatf("flush_after_c%0d", k), S0, 1'b0, 32'h0, 1'b0, 1'b0);
         #1;
         e = q.pop_front();
         total++;
         if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.nm, obs(), e.v);
         else passed++;
      end
   endtask
   task automatic test_reset_mid();
      exp_t e;
      for (int k = -1; k <= 12; k++) begin
         next();
         idle_in();
         id_load = k == -1;
         id_load_waddr = k == -1 ? 5'd8 : 5'd0;
         ex_div_start = k == 0;
         rst = k == 5;
         id_rs = k >= 6 ? 5'd8 : 5'd0;
         id_use_rs = k >= 6;
         if (k == -1) push("rstmid_pre", S0, 1'b0, 32'h0, 1'b0, 1'b0);
         else if (k <= 5) push($sformatf("rstmid_div_c%0d", k), S_MD, 1'b0, 32'h0, k >= 1, 1'b0);
         else push($sformatf("rstmid_after_c%0d", k), S0, 1'b0, 32'h0, 1'b0, 1'b0);
         #1;
         e = q.pop_front();
         total++;
         if (obs() !== e.v) $display("FAIL %s: got %h want %h", e.nm, obs(), e.v);
         else passed++;
      end
   endtask
   initial begin
      test_reset();
      test_load_use();
      test_priority();
      test_md("div", 1'b1, 1'b0, 1'b0);
      test_md("div_mem", 1'b1, 1'b0, 1'b1);
      test_md("mul", 1'b0, 1'b1, 1'b0);
      test_md("div_over_mul", 1'b1, 1'b1, 1'b0);
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
